// File: rtl/fdre_delay_line.sv
// fdre_delay_line: WIDTH x DEPTH clock-enabled register chain with runtime tap select and a saturating fill count.
// Optional feature: define FDRE_DELAY_LINE_GSR_EN to honour the asynchronous global set/reset glbl.GSR.
module fdre_delay_line #(
  parameter int unsigned       WIDTH = 8,
  parameter int unsigned       DEPTH = 16,
  parameter int unsigned       AW    = 4,
  parameter int unsigned       CW    = 5,
  parameter logic [WIDTH-1:0]  INIT  = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    A,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_LAST,
  output logic [CW-1:0]    COUNT,
  output logic             VALID,
  output logic             FULL
);

  if (DEPTH < 2 || (64'd1 << AW) < 64'(DEPTH) || (64'd1 << CW) <= 64'(DEPTH) ||
      WIDTH < 1 || WIDTH > 64) begin : g_bad_params
    $fatal(1, "fdre_delay_line: illegal parameters (need DEPTH>=2, 2**AW>=DEPTH, 2**CW>DEPTH)");
  end

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_TAP   = AW'(DEPTH - 1);

  // NOTE: every stage is reset to INIT, so this array must map to flops, never to a RAM macro.
  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_a_eff;

`ifdef FDRE_DELAY_LINE_GSR_EN
  logic w_gsr;
  assign w_gsr = glbl.GSR;

  always_ff @(posedge C or posedge w_gsr) begin
    if (w_gsr) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= INIT;
      r_count <= '0;
    end else begin
`else
  always_ff @(posedge C) begin
    begin
`endif
      // NOTE: non-blocking assignments let every stage sample its neighbour's old value in one edge.
      // Unknown R or CE deliberately poisons the state instead of silently holding it.
      case (R)
        1'b1: begin
          for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= INIT;
          r_count <= '0;
        end
        1'b0: begin
          case (CE)
            1'b1: begin
              r_stage[0] <= D;
              for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
              if (r_count != FULL_COUNT) r_count <= r_count + CW'(1);
            end
            1'b0: ;
            default: begin
              for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= 'x;
              r_count <= 'x;
            end
          endcase
        end
        default: begin
          for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= 'x;
          r_count <= 'x;
        end
      endcase
    end
  end

  // Out-of-range taps clamp to the last stage rather than wrapping.
  assign w_a_eff = (32'(A) < DEPTH) ? A : LAST_TAP;

  assign Q      = r_stage[w_a_eff];
  assign Q_LAST = r_stage[DEPTH-1];
  assign COUNT  = r_count;
  assign VALID  = 32'(r_count) > 32'(w_a_eff);
  assign FULL   = (r_count == FULL_COUNT);

endmodule

// File: tb/tb_fdre_delay_line.sv
// Directed bench for fdre_delay_line: a DEPTH=16 and a DEPTH=12 instance share all inputs.
`timescale 1ps/1ps
module tb_fdre_delay_line;

  localparam logic [7:0] INIT = 8'hA5;

  logic       clk = 1'b0;
  logic       R, CE;
  logic [7:0] D;
  logic [3:0] A;

  logic [7:0] q16, qlast16, q12, qlast12;
  logic [4:0] count16;
  logic [3:0] count12;
  logic       valid16, full16, valid12, full12;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;  // samples shifted in since the last reset

  always #5000 clk = ~clk;

  fdre_delay_line #(.WIDTH(8), .DEPTH(16), .AW(4), .CW(5), .INIT(INIT)) u_dut16 (
    .C(clk), .R(R), .CE(CE), .D(D), .A(A),
    .Q(q16), .Q_LAST(qlast16), .COUNT(count16), .VALID(valid16), .FULL(full16)
  );

  fdre_delay_line #(.WIDTH(8), .DEPTH(12), .AW(4), .CW(4), .INIT(INIT)) u_dut12 (
    .C(clk), .R(R), .CE(CE), .D(D), .A(A),
    .Q(q12), .Q_LAST(qlast12), .COUNT(count12), .VALID(valid12), .FULL(full12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int a_eff(input int a, input int depth);
    return (a < depth) ? a : depth - 1;
  endfunction

  // Sample k (1-based since reset) carries data value k, so tap e holds n-e once n > e.
  function automatic logic [7:0] exp_tap(input int cnt, input int depth, input int a);
    int e = a_eff(a, depth);
    if (cnt > e) return 8'(cnt - e);
    return INIT;
  endfunction

  task automatic check_dut(input string tag);
    int a = int'(A);
    int c16 = (n > 16) ? 16 : n;
    int c12 = (n > 12) ? 12 : n;
    check({tag, "/q16"},     32'(q16),     32'(exp_tap(n, 16, a)));
    check({tag, "/valid16"}, 32'(valid16), (n > a_eff(a, 16)) ? 1 : 0);
    check({tag, "/count16"}, 32'(count16), c16);
    check({tag, "/full16"},  32'(full16),  (n >= 16) ? 1 : 0);
    check({tag, "/qlast16"}, 32'(qlast16), 32'(exp_tap(n, 16, 15)));
    check({tag, "/q12"},     32'(q12),     32'(exp_tap(n, 12, a)));
    check({tag, "/valid12"}, 32'(valid12), (n > a_eff(a, 12)) ? 1 : 0);
    check({tag, "/count12"}, 32'(count12), c12);
    check({tag, "/full12"},  32'(full12),  (n >= 12) ? 1 : 0);
    check({tag, "/qlast12"}, 32'(qlast12), 32'(exp_tap(n, 12, 11)));
  endtask

  task automatic tick(input logic r, input logic ce, input logic [7:0] d);
    R = r; CE = ce; D = d;
    @(posedge clk);
    #100;
    if (r) n = 0;
    else if (ce) n++;
  endtask

  initial begin
    R = 1'b1; CE = 1'b0; D = '0; A = 4'd3;

    tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b0, 8'h00);
    check_dut("reset");
    check("reset/q16_const", 32'(q16), 32'hA5);

    // Fill at A=3: Q shows sample 1 after edge 4, FULL on edge 16, COUNT saturates by edge 20.
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b1, 8'(n + 1));
      check_dut($sformatf("fill%0d", k));
    end
    check("fill/count16_sat", 32'(count16), 32'd16);

    // Reset and CE together: D=FF must not be captured.
    tick(1'b1, 1'b1, 8'hFF);
    check_dut("r_ce_prio");

    A = 4'd1;
    tick(1'b0, 1'b1, 8'(n + 1));
    tick(1'b0, 1'b1, 8'(n + 1));
    check_dut("two_samples");
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, 1'b0, 8'h77);
      check_dut($sformatf("hold%0d", k));
    end
    A = 4'd0;
    tick(1'b0, 1'b1, 8'(n + 1));
    check_dut("resume");
    check("resume/count16_const", 32'(count16), 32'd3);
    check("resume/q0_const", 32'(q16), 32'h03);

    for (int k = 0; k < 6; k++) begin
      tick(1'b0, 1'b1, 8'(n + 1));
      check_dut($sformatf("to9_%0d", k));
    end
    check("mid/count16_9", 32'(count16), 32'd9);

    // Reset mid-stream: VALID low for every tap immediately after.
    tick(1'b1, 1'b1, 8'hFF);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check_dut($sformatf("midrst_a%0d", a));
    end

    // Refill at A=5: first post-reset sample reaches tap 5 on edge 6.
    A = 4'd5;
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 1'b1, 8'(n + 1));
      check_dut($sformatf("refill%0d", k));
    end

    // Hold with pipes full, then sweep taps combinationally including clamped ones.
    tick(1'b0, 1'b0, 8'h77);
    A = 4'd15;
    #1;
    check("clamp/q12_a15", 32'(q12), 32'h05);
    check("clamp/q16_a15", 32'(q16), 32'h01);
    for (int a = 0; a < 16; a++) begin
      A = 4'(a);
      #1;
      check_dut($sformatf("sweep_a%0d", a));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
